// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data-memory responder for the CPU load/store port.
// Accepts one request at a time, waits WAIT_CYCLES, then pulses rsp_valid.
module dmem_responder #(
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_read,
  input  logic        req_write,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WRD_W = 15;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WRD_W-1:0]   word_q, word_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic               req_ready_q, rsp_valid_q, err_q, err_d;
  logic [15:0]        rsp_rdata_q, rsp_rdata_d;

  logic [15:0]        mem_q [DEPTH];

  logic               accept, commit, in_range, mem_we;
  logic [WRD_W-1:0]   eff_word;
  logic [15:0]        eff_wdata;
  logic               eff_rd, eff_wr;
  logic [IDX_W-1:0]   mem_idx;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = req_addr[0];

  // With zero wait states the commit edge is the acceptance edge, so the live request is used
  always_comb begin
    accept    = (state_q == S_IDLE) && (req_read || req_write);
    eff_word  = (state_q == S_IDLE) ? req_addr[15:1] : word_q;
    eff_wdata = (state_q == S_IDLE) ? req_wdata      : wdata_q;
    eff_rd    = (state_q == S_IDLE) ? req_read       : rd_q;
    eff_wr    = (state_q == S_IDLE) ? req_write      : wr_q;
    in_range  = 16'(eff_word) < 16'(DEPTH);
    mem_idx   = eff_word[IDX_W-1:0];
  end

  // Next-state, request latch and registered-output next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          word_d  = req_addr[15:1];
          wdata_d = req_wdata;
          rd_d    = req_read;
          wr_d    = req_write;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    commit      = (state_d == S_RESP) && (state_q != S_RESP);
    mem_we      = rst_n && commit && eff_wr && in_range;
    rsp_rdata_d = (commit && eff_rd && !eff_wr && in_range) ? mem_q[mem_idx] : 16'h0000;
    err_d       = err_q || (commit && (!in_range || (eff_rd && eff_wr)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      req_ready_q <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_RESP);
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  // Storage is deliberately not reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= eff_wdata;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err       = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the 16-bit CPU's load/store port, i.e. the memory-side end of the CPU's addr/write_data/mem_read/mem_write interface.
- Replaces the zero-latency data memory with a handshaked, multi-cycle responder:
  - latches one request at a time;
  - inserts a parameterised number of wait states;
  - performs the read or write;
  - returns a one-cycle response pulse.
- Sticky error flag for out-of-range and malformed requests.

Parameters:
- DEPTH, 2048, number of 16-bit words in storage (power of two, at most 32768).
- WAIT_CYCLES, 2, wait states between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_addr  input  16  byte address; bit 0 ignored (word-aligned, matches PC+2 stepping).
- req_wdata  input  16  store data.
- req_read  input  1  read request (load).
- req_write  input  1  write request (store).
- req_ready  output  1  high when a new request can be accepted.
- rsp_valid  output  1  one-cycle pulse marking request completion.
- rsp_rdata  output  16  load data, valid only while rsp_valid=1 on a read; 0 otherwise.
- err  output  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, err=0, wait counter=0, latched request cleared.
  - Storage array is NOT reset; contents survive reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance occurs on a rising edge where req_read|req_write=1. At that edge, latch addr, wdata and type, and load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - If neither request bit is set, stay in IDLE.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when it reaches 1, next state is RESP.
  - Request inputs are ignored while in WAIT.
- RESP:
  - req_ready=0, rsp_valid=1 for exactly one cycle; next state is always IDLE.
- Write commit:
  - Array write occurs on the edge that enters RESP.
  - Read data is sampled from the array on that same edge and registered into rsp_rdata.
  - rsp_rdata returns to 0 on the edge leaving RESP.
- Latency: rsp_valid asserts in the (WAIT_CYCLES+1)th cycle after the acceptance edge.
- Throughput: one request per WAIT_CYCLES+2 cycles. There is no back-to-back acceptance, because req_ready is low in RESP.
- Word index = latched_addr[15:1].
- Out of range (word index >= DEPTH):
  - write is dropped, read returns 0, err set on entry to RESP;
  - the response still completes normally.
- Simultaneous req_read and req_write at acceptance:
  - treated as a write;
  - err set on entry to RESP.
- Read-after-write to the same address in successive transactions returns the new data.
- Reset mid-transaction (WAIT or RESP):
  - abort immediately to the reset values above;
  - a write is not committed if reset arrives before the edge entering RESP.
- Request signals held high across the RESP→IDLE transition: the request is accepted again on the first IDLE edge (requester must drop them after rsp_valid).
- No combinational path from req_* inputs to any output; all outputs are registered or decoded from state.

Test Plan:
- Reset then idle: release rst_n, no requests for 10 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0, err=0 throughout.
- Write/read, WAIT_CYCLES=2:
  - write addr 0x0010 data 0xBEEF -> rsp_valid pulses exactly 3 cycles after acceptance edge, rsp_rdata=0;
  - then read 0x0010 -> rsp_rdata=0xBEEF with rsp_valid, same latency;
  - read 0x0011 -> also 0xBEEF (bit 0 ignored).
- Zero wait states: WAIT_CYCLES=0, write 0x0002=0x1234 then read 0x0002 -> each rsp_valid one cycle after acceptance, read returns 0x1234, req_ready low for exactly 1 cycle per transaction.
- Out of range, DEPTH=2048:
  - write 0x1000=0xAAAA -> err=1;
  - read 0x1000 -> rsp_rdata=0;
  - read 0x0000 still returns prior contents; err stays 1 until reset.
- Simultaneous read+write: assert both with addr 0x0004, wdata 0x5555 -> treated as write, err=1; subsequent read 0x0004 returns 0x5555.
- Reset mid-operation: write 0x0006=0x7777 accepted, assert rst_n low during WAIT -> outputs return to reset values immediately, read 0x0006 afterwards returns the pre-test value (not 0x7777); a prior committed location is unchanged.
